wb_downsize: RTL and testbench
==============================

WB_DOWNSIZE -- requirements
Module: wb_downsize

Interface
REQ-001 Parameter WIDE_WIDTH, default 128: data width of the upstream (CPU-side) Wishbone slave port.
REQ-002 Parameter NARROW_WIDTH, default 32: data width of the downstream Wishbone master port; WIDE_WIDTH SHALL be an integer multiple R of NARROW_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 32: address width on both ports.
REQ-004 Parameter GRANULARITY, default 32: bits per select lane on both ports; addresses count GRANULARITY-sized units; SW=WIDE_WIDTH/GRANULARITY, NW=NARROW_WIDTH/GRANULARITY.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 s_adr_i  input  ADDR_WIDTH  upstream address, aligned to SW units.
REQ-008 s_dat_i  input  WIDE_WIDTH  upstream write data.
REQ-009 s_dat_o  output  WIDE_WIDTH  assembled read data.
REQ-010 s_we_i / s_sel_i / s_stb_i / s_cyc_i  input  1/SW/1/1  upstream write-enable, lane select, strobe, cycle.
REQ-011 s_ack_o / s_err_o / s_rty_o  output  1 each  upstream termination.
REQ-012 m_adr_o / m_dat_o / m_we_o / m_sel_o / m_stb_o / m_cyc_o  output  ADDR_WIDTH/NARROW_WIDTH/1/NW/1/1  downstream request.
REQ-013 m_dat_i / m_ack_i / m_err_i / m_rty_i  input  NARROW_WIDTH/1/1/1  downstream response.

Function
REQ-014 States SHALL be IDLE, BEAT, DONE.
REQ-015 IDLE: on s_cyc_i&s_stb_i, latch adr, dat, we, sel; clear s_dat_o to 0; go BEAT at first beat k with nonzero sel slice, or straight to DONE if s_sel_i==0 (no downstream cycle).
REQ-016 Beat k (0..R-1) covers s_sel_i[k*NW +: NW] and data bits [k*NARROW_WIDTH +: NARROW_WIDTH]; beats issued in ascending k; beats with zero sel slice SHALL be skipped with no bus cycle.
REQ-017 BEAT: m_cyc_o=m_stb_o=1, m_adr_o=latched adr + k*NW, m_sel_o=slice k, m_we_o=latched we, m_dat_o=data slice k; all held stable until termination.
REQ-018 On m_ack_i in BEAT: if read, capture m_dat_i into s_dat_o slice k; advance to next enabled beat the following cycle with m_stb_o held high, or to DONE if none remain.
REQ-019 Skipped-lane read data SHALL read 0; s_dat_o SHALL hold its value from DONE until next request acceptance.
REQ-020 DONE: s_ack_o=1 for exactly one cycle, m_cyc_o=m_stb_o=0, then IDLE.
REQ-021 m_err_i in BEAT (priority err > rty > ack if simultaneous): abort remaining beats, drop m_cyc_o/m_stb_o next cycle, assert s_err_o one cycle, then IDLE; s_ack_o not asserted.
REQ-022 m_rty_i in BEAT: same as REQ-021 with s_rty_o.
REQ-023 s_cyc_i deasserted in BEAT: m_cyc_o/m_stb_o SHALL drop next cycle, no upstream termination, return IDLE; late m_ack_i ignored.
REQ-024 At most one of s_ack_o/s_err_o/s_rty_o high in any cycle; all outputs registered.
REQ-025 Latency, zero-wait downstream, N enabled beats: request sampled at edge E0, beat i completes at edge Ei, s_ack_o high in cycle after EN; total N+1 cycles.
REQ-026 Each downstream wait state adds exactly one cycle to the beat it occurs in.
REQ-027 Upstream requests while not in IDLE SHALL be ignored (no queuing).

Reset
REQ-028 rst low SHALL immediately force IDLE, and m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o, s_rty_o to 0; m_adr_o, m_dat_o, m_sel_o, s_dat_o to 0.
REQ-029 Reset asserted mid-BEAT SHALL abandon the transaction with no upstream termination; first request after rst release SHALL be accepted normally.

Verification
REQ-030 Read, sel=4'hF, adr=0x100, zero-wait slave returning 0xA0..0xA3 -> m_adr_o 0x100,0x101,0x102,0x103 on consecutive cycles; s_dat_o=0x000000A3_000000A2_000000A1_000000A0; s_ack_o one cycle, 5 cycles after request.
REQ-031 Write, sel=4'b1010, dat=0x44444444_33333333_22222222_11111111 -> exactly 2 beats: adr+1 data 0x22222222, adr+3 data 0x44444444, m_we_o=1; s_ack_o after 3 cycles.
REQ-032 sel=4'b0000 -> no m_cyc_o assertion; s_ack_o 2 cycles after request (IDLE->DONE).
REQ-033 Read sel=4'hF, slave gives m_err_i on beat 1 -> beats 2,3 not issued; s_err_o one cycle; s_ack_o never high; next request completes normally.
REQ-034 Slave inserts 2 wait states on beat 0 -> m_adr_o/m_sel_o stable 3 cycles; s_ack_o 7 cycles after request.
REQ-035 rst low during beat 2 -> all outputs 0 asynchronously; after release, sel=4'hF read completes in 5 cycles.

Source files
------------

// File: rtl/wb_downsize.sv
// Wishbone width downsizer: one wide upstream access becomes a run of narrow
// downstream beats in ascending lane order, skipping lanes with no select bits.
module wb_downsize #(
  parameter int WIDE_WIDTH   = 128,
  parameter int NARROW_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int GRANULARITY  = 32,
  localparam int SW = WIDE_WIDTH / GRANULARITY,
  localparam int NW = NARROW_WIDTH / GRANULARITY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_adr_i,
  input  logic [WIDE_WIDTH-1:0]   s_dat_i,
  output logic [WIDE_WIDTH-1:0]   s_dat_o,
  input  logic                    s_we_i,
  input  logic [SW-1:0]           s_sel_i,
  input  logic                    s_stb_i,
  input  logic                    s_cyc_i,
  output logic                    s_ack_o,
  output logic                    s_err_o,
  output logic                    s_rty_o,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  output logic [NARROW_WIDTH-1:0] m_dat_o,
  output logic                    m_we_o,
  output logic [NW-1:0]           m_sel_o,
  output logic                    m_stb_o,
  output logic                    m_cyc_o,
  input  logic [NARROW_WIDTH-1:0] m_dat_i,
  input  logic                    m_ack_i,
  input  logic                    m_err_i,
  input  logic                    m_rty_i
);

  localparam int R  = WIDE_WIDTH / NARROW_WIDTH;
  localparam int KW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [WIDE_WIDTH-1:0]   dat_q;
  logic [SW-1:0]           sel_q;
  logic [KW-1:0]           beat_q;
  logic                    first_vld;
  logic [KW-1:0]           first_idx;
  logic                    nxt_vld;
  logic [KW-1:0]           nxt_idx;

  function automatic logic [ADDR_WIDTH-1:0] beat_adr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [KW-1:0] k);
    return base + ADDR_WIDTH'(k) * ADDR_WIDTH'(NW);
  endfunction

  // Scanning from the top lane down leaves the lowest qualifying lane in the result.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    nxt_vld   = 1'b0;
    nxt_idx   = '0;
    for (int j = R - 1; j >= 0; j--) begin
      if (|s_sel_i[j*NW +: NW]) begin
        first_vld = 1'b1;
        first_idx = KW'(j);
      end
      if ((j > int'(beat_q)) && (|sel_q[j*NW +: NW])) begin
        nxt_vld = 1'b1;
        nxt_idx = KW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
      s_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_rty_o <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_stb_o <= 1'b0;
      m_cyc_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_cyc_i && s_stb_i) begin
            adr_q   <= s_adr_i;
            dat_q   <= s_dat_i;
            sel_q   <= s_sel_i;
            s_dat_o <= '0;
            if (first_vld) begin
              state   <= BEAT;
              beat_q  <= first_idx;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= s_we_i;
              m_adr_o <= beat_adr(s_adr_i, first_idx);
              m_sel_o <= s_sel_i[first_idx*NW +: NW];
              m_dat_o <= s_dat_i[first_idx*NARROW_WIDTH +: NARROW_WIDTH];
            end else begin
              state <= DONE;
            end
          end
        end

        // An abandoned upstream cycle outranks any downstream response in the same cycle.
        BEAT: begin
          if (!s_cyc_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            state   <= IDLE;
          end else if (m_err_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            s_err_o <= 1'b1;
            state   <= DONE;
          end else if (m_rty_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            s_rty_o <= 1'b1;
            state   <= DONE;
          end else if (m_ack_i) begin
            if (!m_we_o) begin
              s_dat_o[beat_q*NARROW_WIDTH +: NARROW_WIDTH] <= m_dat_i;
            end
            if (nxt_vld) begin
              beat_q  <= nxt_idx;
              m_adr_o <= beat_adr(adr_q, nxt_idx);
              m_sel_o <= sel_q[nxt_idx*NW +: NW];
              m_dat_o <= dat_q[nxt_idx*NARROW_WIDTH +: NARROW_WIDTH];
            end else begin
              m_cyc_o <= 1'b0;
              m_stb_o <= 1'b0;
              m_we_o  <= 1'b0;
              s_ack_o <= 1'b1;
              state   <= DONE;
            end
          end
        end

        // Entered with a termination already raised after beats, or with none
        // raised for an empty select, which then takes one extra cycle to ack.
        DONE: begin
          if (s_ack_o || s_err_o || s_rty_o) begin
            s_ack_o <= 1'b0;
            s_err_o <= 1'b0;
            s_rty_o <= 1'b0;
            state   <= IDLE;
          end else begin
            s_ack_o <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_downsize.sv
// Self-checking bench for wb_downsize: directed vector table, hand-written
// abort/reset sequences and randomized requests against a lane-level model.
module tb_wb_downsize;

  localparam int WW    = 128;
  localparam int NWID  = 32;
  localparam int AW    = 32;
  localparam int GR    = 32;
  localparam int SW    = WW / GR;
  localparam int NW    = NWID / GR;
  localparam int R     = WW / NWID;
  localparam int T_NONE = -1;
  localparam int T_ACK  = 0;
  localparam int T_ERR  = 1;
  localparam int T_RTY  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   s_adr_i;
  logic [WW-1:0]   s_dat_i;
  logic [WW-1:0]   s_dat_o;
  logic            s_we_i;
  logic [SW-1:0]   s_sel_i;
  logic            s_stb_i;
  logic            s_cyc_i;
  logic            s_ack_o;
  logic            s_err_o;
  logic            s_rty_o;
  logic [AW-1:0]   m_adr_o;
  logic [NWID-1:0] m_dat_o;
  logic            m_we_o;
  logic [NW-1:0]   m_sel_o;
  logic            m_stb_o;
  logic            m_cyc_o;
  logic [NWID-1:0] m_dat_i;
  logic            m_ack_i;
  logic            m_err_i;
  logic            m_rty_i;

  always #5 clk = ~clk;

  wb_downsize #(
    .WIDE_WIDTH(WW),
    .NARROW_WIDTH(NWID),
    .ADDR_WIDTH(AW),
    .GRANULARITY(GR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_adr_i(s_adr_i),
    .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o),
    .s_we_i(s_we_i),
    .s_sel_i(s_sel_i),
    .s_stb_i(s_stb_i),
    .s_cyc_i(s_cyc_i),
    .s_ack_o(s_ack_o),
    .s_err_o(s_err_o),
    .s_rty_o(s_rty_o),
    .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o),
    .m_we_o(m_we_o),
    .m_sel_o(m_sel_o),
    .m_stb_o(m_stb_o),
    .m_cyc_o(m_cyc_o),
    .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i),
    .m_err_i(m_err_i),
    .m_rty_i(m_rty_i)
  );

  typedef struct packed {
    logic [AW-1:0]   adr;
    logic [NW-1:0]   sel;
    logic [NWID-1:0] dat;
    logic            we;
  } beat_t;

  typedef struct {
    string           name;
    logic [AW-1:0]   adr;
    logic [WW-1:0]   dat;
    logic            we;
    logic [SW-1:0]   sel;
    logic [R-1:0][3:0] waits;
    int              err_at;
    int              rty_at;
    int              exp_term;
    int              exp_lat;
    int              exp_nbeats;
    logic [WW-1:0]   exp_rdat;
  } vec_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  vec_t  vecs[$];

  int n_cmp = 0;
  int n_fail = 0;

  logic [R-1:0][3:0] pl_waits;
  int pl_err_at;
  int pl_rty_at;

  int            sl_beat_no;
  int            sl_wait_left;
  logic          sl_in_beat;
  logic          sl_unstable;
  int            sl_cyc_seen;
  logic [AW-1:0] sl_first_adr;
  logic [NW-1:0] sl_first_sel;

  int       got_term;
  int       got_lat;
  logic [2:0] term_bits;
  logic     term_mcyc;
  logic [3:0] post_bits;

  int         mdl_term;
  int         mdl_lat;
  logic [WW-1:0] mdl_rdat;

  function automatic logic [NWID-1:0] rd_data(input logic [AW-1:0] a);
    return a + 32'hA0 - 32'h100;
  endfunction

  task automatic check_output(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [AW-1:0] adr, input logic [WW-1:0] dat,
                                input logic we, input logic [SW-1:0] sel, input logic en);
    s_adr_i = adr;
    s_dat_i = dat;
    s_we_i  = we;
    s_sel_i = sel;
    s_cyc_i = en;
    s_stb_i = en;
  endtask

  task automatic reset_slave();
    obs_q.delete();
    sl_beat_no  = 0;
    sl_wait_left = 0;
    sl_in_beat  = 1'b0;
    sl_unstable = 1'b0;
    sl_cyc_seen = 0;
  endtask

  // Downstream slave: per-beat wait states, then a termination; err/rty come
  // with lower-priority responses raised alongside to exercise priority.
  task automatic slave_step();
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_rty_i = 1'b0;
    m_dat_i = '0;
    if (m_cyc_o) sl_cyc_seen++;
    if (m_cyc_o && m_stb_o) begin
      if (!sl_in_beat) begin
        sl_in_beat   = 1'b1;
        sl_wait_left = (sl_beat_no < R) ? int'(pl_waits[sl_beat_no]) : 0;
        sl_first_adr = m_adr_o;
        sl_first_sel = m_sel_o;
      end
      if (m_adr_o !== sl_first_adr || m_sel_o !== sl_first_sel) sl_unstable = 1'b1;
      if (sl_wait_left > 0) begin
        sl_wait_left--;
      end else begin
        obs_q.push_back('{m_adr_o, m_sel_o, m_dat_o, m_we_o});
        m_dat_i = rd_data(m_adr_o);
        m_ack_i = 1'b1;
        if (sl_beat_no == pl_err_at) begin
          m_err_i = 1'b1;
          m_rty_i = 1'b1;
        end else if (sl_beat_no == pl_rty_at) begin
          m_rty_i = 1'b1;
        end
        sl_in_beat = 1'b0;
        sl_beat_no++;
      end
    end else begin
      sl_in_beat = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [AW-1:0] adr, input logic [WW-1:0] dat,
                         input logic we, input logic [SW-1:0] sel);
    reset_slave();
    got_term  = T_NONE;
    got_lat   = 0;
    term_bits = '0;
    term_mcyc = 1'b0;
    @(negedge clk);
    apply_stimulus(adr, dat, we, sel, 1'b1);
    for (int c = 1; c <= 100 && got_term == T_NONE; c++) begin
      @(negedge clk);
      if (s_ack_o || s_err_o || s_rty_o) begin
        got_term  = s_err_o ? T_ERR : (s_rty_o ? T_RTY : T_ACK);
        got_lat   = c;
        term_bits = {s_ack_o, s_err_o, s_rty_o};
        term_mcyc = m_cyc_o;
      end
      slave_step();
    end
    @(negedge clk);
    post_bits = {s_ack_o, s_err_o, s_rty_o, m_cyc_o};
    apply_stimulus(adr, dat, we, sel, 1'b0);
    slave_step();
  endtask

  // Lane-level reference: walk lanes in order, accumulate beat time, stop at a fault.
  task automatic run_model(input logic [AW-1:0] adr, input logic [WW-1:0] dat,
                           input logic we, input logic [SW-1:0] sel);
    int n;
    int t;
    exp_q.delete();
    n = 0;
    t = 0;
    mdl_term = T_ACK;
    mdl_rdat = '0;
    mdl_lat  = 2;
    for (int k = 0; k < R; k++) begin
      if (mdl_term == T_ACK && sel[k*NW +: NW] != '0) begin
        exp_q.push_back('{adr + AW'(k * NW), sel[k*NW +: NW], dat[k*NWID +: NWID], we});
        t += int'(pl_waits[n]) + 1;
        if (n == pl_err_at) mdl_term = T_ERR;
        else if (n == pl_rty_at) mdl_term = T_RTY;
        else if (!we) mdl_rdat[k*NWID +: NWID] = rd_data(adr + AW'(k * NW));
        mdl_lat = t + 1;
        n++;
      end
    end
  endtask

  task automatic compare_txn(input string name, input int exp_term, input int exp_lat,
                             input int exp_nbeats, input logic [WW-1:0] exp_rdat);
    check_output({name, ".term"}, WW'(got_term), WW'(exp_term));
    check_output({name, ".latency"}, WW'(got_lat), WW'(exp_lat));
    check_output({name, ".onehot"}, WW'($countones(term_bits)), WW'(1));
    check_output({name, ".mcyc_at_term"}, WW'(term_mcyc), WW'(0));
    check_output({name, ".quiet_after"}, WW'(post_bits), WW'(0));
    check_output({name, ".nbeats"}, WW'(obs_q.size()), WW'(exp_nbeats));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_output($sformatf("%s.beat%0d", name, i), WW'(obs_q[i]), WW'(exp_q[i]));
    check_output({name, ".stable"}, WW'(sl_unstable), WW'(0));
    if (exp_term == T_ACK) check_output({name, ".rdata"}, s_dat_o, exp_rdat);
  endtask

  initial begin
    logic [AW-1:0] adr;
    logic [WW-1:0] dat;
    logic          we;
    logic [SW-1:0] sel;
    logic [3:0]    quiet;

    vecs.push_back('{"rd4", 32'h100, '0, 1'b0, 4'hF, 16'h0000, -1, -1, T_ACK, 5, 4,
                     128'h000000A3_000000A2_000000A1_000000A0});
    vecs.push_back('{"wr2", 32'h100, 128'h44444444_33333333_22222222_11111111, 1'b1, 4'b1010,
                     16'h0000, -1, -1, T_ACK, 3, 2, '0});
    vecs.push_back('{"sel0", 32'h180, 128'h5, 1'b0, 4'b0000, 16'h0000, -1, -1, T_ACK, 2, 0, '0});
    vecs.push_back('{"err1", 32'h100, '0, 1'b0, 4'hF, 16'h0000, 1, -1, T_ERR, 3, 2, '0});
    vecs.push_back('{"after_err", 32'h104, '0, 1'b0, 4'hF, 16'h0000, -1, -1, T_ACK, 5, 4,
                     128'h000000A7_000000A6_000000A5_000000A4});
    vecs.push_back('{"wait2", 32'h200, '0, 1'b0, 4'hF, 16'h0002, -1, -1, T_ACK, 7, 4,
                     128'h000001A3_000001A2_000001A1_000001A0});
    vecs.push_back('{"rty0", 32'h10, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, 4'b0110,
                     16'h0000, -1, 0, T_RTY, 2, 1, '0});
    vecs.push_back('{"rd9", 32'h40, '0, 1'b0, 4'b1001, 16'h0000, -1, -1, T_ACK, 3, 2,
                     128'hFFFFFFE3_00000000_00000000_FFFFFFE0});
    vecs.push_back('{"rd_lane2", 32'h300, '0, 1'b0, 4'b0100, 16'h0001, -1, -1, T_ACK, 3, 1,
                     128'h00000000_000002A2_00000000_00000000});

    rst = 1'b1;
    apply_stimulus('0, '0, 1'b0, '0, 1'b0);
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_rty_i = 1'b0;
    m_dat_i = '0;
    pl_waits = '0;
    pl_err_at = -1;
    pl_rty_at = -1;
    #3 rst = 1'b0;
    #5;
    check_output("reset.ctrl", WW'({m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o, s_rty_o}), WW'(0));
    check_output("reset.data", WW'({m_adr_o, m_dat_o, m_sel_o}), WW'(0));
    check_output("reset.sdat", s_dat_o, '0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      pl_waits  = vecs[i].waits;
      pl_err_at = vecs[i].err_at;
      pl_rty_at = vecs[i].rty_at;
      run_txn(vecs[i].adr, vecs[i].dat, vecs[i].we, vecs[i].sel);
      run_model(vecs[i].adr, vecs[i].dat, vecs[i].we, vecs[i].sel);
      compare_txn(vecs[i].name, vecs[i].exp_term, vecs[i].exp_lat, vecs[i].exp_nbeats, vecs[i].exp_rdat);
      if (vecs[i].sel == '0) check_output({vecs[i].name, ".no_mcyc"}, WW'(sl_cyc_seen), WW'(0));
    end

    // Upstream drops the cycle in the same cycle the slave acks beat 1; a later ack must be ignored.
    pl_waits  = 16'h0010;
    pl_err_at = -1;
    pl_rty_at = -1;
    reset_slave();
    @(negedge clk);
    apply_stimulus(32'h500, '0, 1'b0, 4'hF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      slave_step();
    end
    apply_stimulus(32'h500, '0, 1'b0, 4'hF, 1'b0);
    @(negedge clk);
    check_output("abort.drop", WW'({m_cyc_o, m_stb_o}), WW'(0));
    check_output("abort.nbeats", WW'(obs_q.size()), WW'(2));
    m_ack_i = 1'b1;
    quiet = '0;
    repeat (3) begin
      @(negedge clk);
      quiet = quiet | {s_ack_o, s_err_o, s_rty_o, m_cyc_o};
    end
    m_ack_i = 1'b0;
    check_output("abort.no_term", WW'(quiet), WW'(0));

    // Asynchronous reset while beat 2 is stretched by wait states.
    pl_waits = 16'h0F00;
    reset_slave();
    @(negedge clk);
    apply_stimulus(32'h100, '0, 1'b0, 4'hF, 1'b1);
    repeat (4) begin
      @(negedge clk);
      slave_step();
    end
    check_output("rst.in_beat2", WW'({m_cyc_o, m_adr_o}), WW'({1'b1, 32'h102}));
    #2 rst = 1'b0;
    #1;
    check_output("rst.ctrl", WW'({m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o, s_rty_o}), WW'(0));
    check_output("rst.data", WW'({m_adr_o, m_dat_o, m_sel_o}), WW'(0));
    check_output("rst.sdat", s_dat_o, '0);
    apply_stimulus('0, '0, 1'b0, '0, 1'b0);
    m_ack_i = 1'b0;
    m_dat_i = '0;
    @(negedge clk);
    rst = 1'b1;
    check_output("rst.quiet", WW'({s_ack_o, s_err_o, s_rty_o, m_cyc_o}), WW'(0));
    pl_waits = '0;
    run_txn(32'h100, '0, 1'b0, 4'hF);
    run_model(32'h100, '0, 1'b0, 4'hF);
    compare_txn("rst.after", T_ACK, 5, 4, 128'h000000A3_000000A2_000000A1_000000A0);

    for (int i = 0; i < 40; i++) begin
      adr = $urandom() & 32'hFFFF_FFFC;
      dat = {$urandom(), $urandom(), $urandom(), $urandom()};
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      for (int b = 0; b < R; b++) pl_waits[b] = 4'($urandom_range(0, 2));
      pl_err_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 3)) : -1;
      pl_rty_at = (pl_err_at < 0 && $urandom_range(0, 6) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(adr, dat, we, sel);
      run_model(adr, dat, we, sel);
      compare_txn($sformatf("rnd%0d", i), mdl_term, mdl_lat, exp_q.size(), mdl_rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
